// File: rtl/gfx_pkg.sv
// Shared graphics definitions: rasterizer FSM encoding and default bus widths.
package gfx_pkg;

  localparam int unsigned COORD_W_DEF = 10;
  localparam int unsigned COLOR_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } rast_state_e;

endpackage

// File: rtl/line_setup.sv
// Combinational Bresenham setup: absolute deltas, step directions, initial error.
module line_setup
  import gfx_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input  logic [COORD_W-1:0]        i_x0,
  input  logic [COORD_W-1:0]        i_y0,
  input  logic [COORD_W-1:0]        i_x1,
  input  logic [COORD_W-1:0]        i_y1,
  output logic [COORD_W-1:0]        o_dx,
  output logic [COORD_W-1:0]        o_dy,
  output logic                      o_sx_neg,
  output logic                      o_sy_neg,
  output logic signed [COORD_W+1:0] o_err
);

  logic w_sx_neg;
  logic w_sy_neg;
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;

  assign w_sx_neg = (i_x1 < i_x0);
  assign w_sy_neg = (i_y1 < i_y0);
  assign w_dx     = w_sx_neg ? (i_x0 - i_x1) : (i_x1 - i_x0);
  assign w_dy     = w_sy_neg ? (i_y0 - i_y1) : (i_y1 - i_y0);

  // Two guard bits keep dx-dy and later 2*err representable for any endpoints.
  assign o_err    = $signed({2'b00, w_dx}) - $signed({2'b00, w_dy});
  assign o_dx     = w_dx;
  assign o_dy     = w_dy;
  assign o_sx_neg = w_sx_neg;
  assign o_sy_neg = w_sy_neg;

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one endpoint pair per command and streams
// pixels from (x0,y0) to (x1,y1) with rts/rtr handshakes on both sides.
module line_rasterizer
  import gfx_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned COLOR_W = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] color,
  input  logic               in_rts,
  output logic               in_rtr,
  output logic               out_rts,
  input  logic               out_rtr,
  output logic [COORD_W-1:0] draw_x,
  output logic [COORD_W-1:0] draw_y,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned ERR_W = COORD_W + 2;
  localparam int unsigned E2_W  = COORD_W + 3;

  rast_state_e r_state;
  rast_state_e w_state_nxt;

  logic [COORD_W-1:0]      r_x0, r_y0, r_x1, r_y1;
  logic [COORD_W-1:0]      r_dx, r_dy;
  logic [COORD_W-1:0]      r_draw_x, r_draw_y;
  logic [COLOR_W-1:0]      r_color;
  logic                    r_sx_neg, r_sy_neg;
  logic signed [ERR_W-1:0] r_err;

  logic [COORD_W-1:0]      w_dx, w_dy;
  logic                    w_sx_neg, w_sy_neg;
  logic signed [ERR_W-1:0] w_err0;
  logic signed [ERR_W-1:0] w_err_nxt;
  logic signed [E2_W-1:0]  w_e2, w_dx_e2, w_dy_e2;
  logic                    w_in_xfer, w_out_xfer, w_step_x, w_step_y;

  line_setup #(.COORD_W(COORD_W)) u_setup (
    .i_x0     (r_x0),
    .i_y0     (r_y0),
    .i_x1     (r_x1),
    .i_y1     (r_y1),
    .o_dx     (w_dx),
    .o_dy     (w_dy),
    .o_sx_neg (w_sx_neg),
    .o_sy_neg (w_sy_neg),
    .o_err    (w_err0)
  );

  assign in_rtr     = (r_state == IDLE);
  assign out_rts    = (r_state == DRAW);
  assign busy       = (r_state != IDLE);
  assign draw_x     = r_draw_x;
  assign draw_y     = r_draw_y;
  assign out_color  = r_color;
  assign out_last   = (r_state == DRAW) && (r_draw_x == r_x1) && (r_draw_y == r_y1);

  assign w_in_xfer  = in_rts && in_rtr;
  assign w_out_xfer = out_rts && out_rtr;

  // Error stepping in one extra bit so 2*err never wraps.
  assign w_e2       = {r_err, 1'b0};
  assign w_dx_e2    = $signed({3'b000, r_dx});
  assign w_dy_e2    = $signed({3'b000, r_dy});
  assign w_step_x   = (w_e2 > -w_dy_e2);
  assign w_step_y   = (w_e2 < w_dx_e2);

  always_comb begin
    w_err_nxt = r_err;
    if (w_step_x) w_err_nxt = w_err_nxt - $signed({2'b00, r_dy});
    if (w_step_y) w_err_nxt = w_err_nxt + $signed({2'b00, r_dx});
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_in_xfer) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = DRAW;
      DRAW:    if (w_out_xfer && out_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command capture, setup load, and per-pixel advance.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_color  <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_err    <= '0;
      r_draw_x <= '0;
      r_draw_y <= '0;
    end else if (w_in_xfer) begin
      r_x0    <= x0;
      r_y0    <= y0;
      r_x1    <= x1;
      r_y1    <= y1;
      r_color <= color;
    end else if (r_state == SETUP) begin
      r_dx     <= w_dx;
      r_dy     <= w_dy;
      r_sx_neg <= w_sx_neg;
      r_sy_neg <= w_sy_neg;
      r_err    <= w_err0;
      r_draw_x <= r_x0;
      r_draw_y <= r_y0;
    end else if (w_out_xfer && !out_last) begin
      r_err <= w_err_nxt;
      if (w_step_x) r_draw_x <= r_sx_neg ? (r_draw_x - COORD_W'(1)) : (r_draw_x + COORD_W'(1));
      if (w_step_y) r_draw_y <= r_sy_neg ? (r_draw_y - COORD_W'(1)) : (r_draw_y + COORD_W'(1));
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Scoreboard bench for line_rasterizer: expected pixels are queued per command
// and compared as the DUT hands them over.
module tb_line_rasterizer;

  localparam int CW = 10;
  localparam int KW = 12;

  logic          clk = 1'b0;
  logic          rst_;
  logic [CW-1:0] x0, y0, x1, y1;
  logic [KW-1:0] color;
  logic          in_rts, in_rtr, out_rts, out_rtr, out_last, busy;
  logic [CW-1:0] draw_x, draw_y;
  logic [KW-1:0] out_color;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x;
    int y;
    int c;
    bit last;
  } pix_t;

  pix_t exp_q[$];

  line_rasterizer #(.COORD_W(CW), .COLOR_W(KW)) dut (
    .clk(clk), .rst_(rst_),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
    .in_rts(in_rts), .in_rtr(in_rtr),
    .out_rts(out_rts), .out_rtr(out_rtr),
    .draw_x(draw_x), .draw_y(draw_y), .out_color(out_color),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int len_of(input int ax, input int ay, input int bx, input int by);
    int dx = (bx > ax) ? bx - ax : ax - bx;
    int dy = (by > ay) ? by - ay : ay - by;
    return ((dx > dy) ? dx : dy) + 1;
  endfunction

  task automatic push_pix(input int x, input int y, input int c, input bit last);
    pix_t p;
    p.x = x; p.y = y; p.c = c; p.last = last;
    exp_q.push_back(p);
  endtask

  // Reference Bresenham walk in plain integers.
  task automatic model_line(input int ax, input int ay, input int bx, input int by, input int c);
    int x = ax, y = ay, e2;
    int dx = (bx > ax) ? bx - ax : ax - bx;
    int dy = (by > ay) ? by - ay : ay - by;
    int sx = (bx >= ax) ? 1 : -1;
    int sy = (by >= ay) ? 1 : -1;
    int err = dx - dy;
    bit done = 0;
    while (!done) begin
      done = (x == bx) && (y == by);
      push_pix(x, y, c, done);
      if (!done) begin
        e2 = 2 * err;
        if (e2 > -dy) begin err -= dy; x += sx; end
        if (e2 < dx)  begin err += dx; y += sy; end
      end
    end
  endtask

  // Entered and left on a falling edge; returns idle cycles waited for in_rtr.
  task automatic send_cmd(input int ax, input int ay, input int bx, input int by,
                          input int c, output int waited);
    waited = 0;
    while (!in_rtr && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_rtr) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_rtr=%b after %0d cycles, want 1", in_rtr, waited);
    end
    x0 = CW'(ax); y0 = CW'(ay); x1 = CW'(bx); y1 = CW'(by); color = KW'(c);
    in_rts = 1'b1;
    @(negedge clk);
    in_rts = 1'b0;
    x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
    color = KW'($urandom);
  endtask

  // Pops/compares pixels; max_pix<=0 means run to out_last.
  task automatic collect(input string name, input int exp_count, input int stall_at,
                         input int stall_len, input int max_pix);
    int cnt = 0, gaps = 0, cycles = 0, first_at = -1, stalls = stall_len;
    bit done = 0;
    pix_t e;
    while (!done && cycles < 5000) begin
      if (out_rts) begin
        if (first_at < 0) first_at = cycles;
        if (cnt == stall_at && stalls > 0) begin
          out_rtr = 1'b0;
          stalls--;
          n_checks++;
          if (exp_q.size() == 0 || draw_x !== CW'(exp_q[0].x) || draw_y !== CW'(exp_q[0].y)) begin
            n_fail++;
            $display("FAIL %s frozen pix%0d: got (%0d,%0d), want held at queue head", name, cnt, draw_x, draw_y);
          end
        end else begin
          out_rtr = 1'b1;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s extra pix%0d: got (%0d,%0d), want no pixel", name, cnt, draw_x, draw_y);
            done = 1;
          end else begin
            e = exp_q.pop_front();
            if (draw_x !== CW'(e.x) || draw_y !== CW'(e.y) || out_color !== KW'(e.c) || out_last !== e.last) begin
              n_fail++;
              $display("FAIL %s pix%0d: got (%0d,%0d) c=%h last=%b, want (%0d,%0d) c=%h last=%b",
                       name, cnt, draw_x, draw_y, out_color, out_last, e.x, e.y, e.c, e.last);
            end
          end
          cnt++;
          if (out_last || (max_pix > 0 && cnt == max_pix)) done = 1;
        end
      end else if (first_at >= 0) begin
        gaps++;
      end
      @(negedge clk);
      cycles++;
    end
    out_rtr = 1'b1;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d pixels, want %0d", name, cnt, exp_count);
    end
    n_checks++;
    if (first_at != 1) begin
      n_fail++;
      $display("FAIL %s latency: first pixel at cycle %0d after SETUP, want 1", name, first_at);
    end
    if (max_pix <= 0) begin
      n_checks++;
      if (cnt != exp_count || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL %s count: got %0d pixels (%0d left), want %0d", name, cnt, exp_q.size(), exp_count);
      end
      n_checks++;
      if (in_rtr !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle_after: got in_rtr=%b busy=%b, want 1 0", name, in_rtr, busy);
      end
      if (stall_len == 0) begin
        n_checks++;
        if (gaps != 0) begin
          n_fail++;
          $display("FAIL %s throughput: got %0d bubbles, want 0", name, gaps);
        end
      end
    end
  endtask

  task automatic check_reset_state(input string name);
    n_checks++;
    if (out_rts !== 1'b0 || in_rtr !== 1'b1 || busy !== 1'b0 || out_last !== 1'b0 ||
        draw_x !== '0 || draw_y !== '0 || out_color !== '0) begin
      n_fail++;
      $display("FAIL %s: got rts=%b rtr=%b busy=%b last=%b xy=(%0d,%0d) c=%h, want 0 1 0 0 (0,0) 000",
               name, out_rts, in_rtr, busy, out_last, draw_x, draw_y, out_color);
    end
  endtask

  task automatic test_reset();
    in_rts = 1'b0; out_rtr = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
    rst_ = 1'b0;
    #1;
    check_reset_state("reset");
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_horizontal();
    int w;
    for (int i = 0; i < 4; i++) push_pix(i, 0, 'h123, i == 3);
    send_cmd(0, 0, 3, 0, 'h123, w);
    collect("horiz", 4, -1, 0, 0);
  endtask

  task automatic test_steep_reverse();
    int w;
    push_pix(5, 5, 'h5A5, 0); push_pix(5, 4, 'h5A5, 0); push_pix(4, 3, 'h5A5, 0);
    push_pix(4, 2, 'h5A5, 0); push_pix(3, 1, 'h5A5, 0); push_pix(3, 0, 'h5A5, 1);
    send_cmd(5, 5, 3, 0, 'h5A5, w);
    collect("steep_rev", 6, -1, 0, 0);
  endtask

  task automatic test_degenerate();
    int w;
    push_pix(7, 7, 'hABC, 1);
    send_cmd(7, 7, 7, 7, 'hABC, w);
    n_checks++;
    if (out_rts !== 1'b0 || busy !== 1'b1 || in_rtr !== 1'b0) begin
      n_fail++;
      $display("FAIL degen_setup: got rts=%b busy=%b rtr=%b, want 0 1 0", out_rts, busy, in_rtr);
    end
    collect("degenerate", 1, -1, 0, 0);
  endtask

  task automatic test_stall();
    int w;
    model_line(0, 0, 10, 4, 'h0F0);
    n_checks++;
    if (exp_q.size() < 3 || exp_q[2].x != 2 || exp_q[2].y != 1) begin
      n_fail++;
      $display("FAIL stall_model: got third pixel not (2,1), want (2,1)");
    end
    send_cmd(0, 0, 10, 4, 'h0F0, w);
    collect("stall", 11, 2, 3, 0);
  endtask

  task automatic test_back_to_back();
    int w;
    model_line(2, 8, 9, 5, 'h321);
    send_cmd(2, 8, 9, 5, 'h321, w);
    collect("b2b_a", len_of(2, 8, 9, 5), -1, 0, 0);
    model_line(9, 5, 2, 8, 'h654);
    send_cmd(9, 5, 2, 8, 'h654, w);
    n_checks++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL b2b_accept: got %0d wait cycles, want 0", w);
    end
    collect("b2b_b", len_of(9, 5, 2, 8), -1, 0, 0);
  endtask

  task automatic test_octants();
    int w, ax, ay, bx, by, c;
    int ddx[8] = '{7, 3, -3, -7, -7, -3, 3, 7};
    int ddy[8] = '{3, 7, 7, 3, -3, -7, -7, -3};
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        ax = 100; ay = 100; bx = 100 + ddx[i]; by = 100 + ddy[i];
      end else begin
        ax = $urandom_range(0, 1023); ay = $urandom_range(0, 1023);
        bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
      end
      c = $urandom_range(0, 4095);
      model_line(ax, ay, bx, by, c);
      send_cmd(ax, ay, bx, by, c, w);
      collect("octant", len_of(ax, ay, bx, by), (i % 3 == 0) ? i : -1, (i % 3 == 0) ? 2 : 0, 0);
    end
  endtask

  task automatic test_long_diagonal();
    int w;
    model_line(0, 0, 1023, 1023, 'hFFF);
    send_cmd(0, 0, 1023, 1023, 'hFFF, w);
    collect("diag1024", 1024, -1, 0, 0);
  endtask

  task automatic test_reset_midline();
    int w, seen = 0;
    model_line(0, 0, 20, 0, 'h777);
    send_cmd(0, 0, 20, 0, 'h777, w);
    collect("mid_pre", 21, -1, 0, 5);
    n_checks++;
    if (out_rts !== 1'b1 || draw_x !== CW'(5)) begin
      n_fail++;
      $display("FAIL mid_active: got rts=%b x=%0d, want 1 5", out_rts, draw_x);
    end
    rst_ = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst_ = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_rts) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_abandon: got %0d stray pixel cycles, want 0", seen);
    end
    push_pix(1, 1, 'h246, 0);
    push_pix(2, 1, 'h246, 1);
    send_cmd(1, 1, 2, 1, 'h246, w);
    collect("mid_after", 2, -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep_reverse();
    test_degenerate();
    test_stall();
    test_back_to_back();
    test_octants();
    test_long_diagonal();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
